// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// load/store port. One transaction is outstanding at a time:
// IDLE (grant) -> ACCESS (MEM_LATENCY cycles) -> RESP (one-cycle rvalid).
//
// Handshake: a requester holds req_i until it sees gnt_o high in the same
// cycle; its address/data are sampled on that edge and ignored afterwards.
// The response is a single-cycle rvalid_o pulse on the owning port,
// MEM_LATENCY+1 cycles after the grant.
//
// Optional feature: define ARB_RR_EN to break ties toward the port that was
// not granted last. Without it, the data port always wins a tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic                  d_byte_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter only needs to hold MEM_LATENCY-1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  // Owner encoding: 1 = data port, 0 = fetch port.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  byte_q, byte_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pick_d;
`ifdef ARB_RR_EN
  logic                  last_q, last_d;
`endif

  // Arbitration: decide which port wins when the FSM is idle.
  always_comb begin
    pick_d = d_req_i;
`ifdef ARB_RR_EN
    if (d_req_i && if_req_i) pick_d = (last_q == OWN_IF);
`endif
    d_gnt_o  = rst_n && (state_q == IDLE) && d_req_i && pick_d;
    if_gnt_o = rst_n && (state_q == IDLE) && if_req_i && !pick_d;
  end

  // Next-state logic: latch the winner on grant, count latency, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    byte_d  = byte_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_gnt_o) begin
          owner_d = OWN_D;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          byte_d  = d_byte_i;
          wdata_d = d_wdata_i;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
`ifdef ARB_RR_EN
          last_d  = OWN_D;
`endif
        end else if (if_gnt_o) begin
          owner_d = OWN_IF;
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          byte_d  = 1'b0;
          wdata_d = '0;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
`ifdef ARB_RR_EN
          last_d  = OWN_IF;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Stores return a zero word so rdata never carries stale bus data.
          rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_D;
      addr_q  <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_RR_EN
      last_q  <= OWN_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Memory port and response outputs decoded from registered state.
  always_comb begin
    mem_req_o   = (state_q == ACCESS);
    mem_we_o    = (state_q == ACCESS) && we_q;
    mem_byte_o  = (state_q == ACCESS) && byte_q;
    mem_addr_o  = (state_q == ACCESS) ? addr_q  : '0;
    mem_wdata_o = (state_q == ACCESS) ? wdata_q : '0;
    if_rvalid_o = (state_q == RESP) && (owner_q == OWN_IF);
    d_rvalid_o  = (state_q == RESP) && (owner_q == OWN_D);
    if_rdata_o  = rdata_q;
    d_rdata_o   = rdata_q;
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; MEM_LATENCY, default 2, cycles from memory request to valid read data (legal range >=1).
REQ-002 Ports SHALL be, one per line, as name direction width meaning:
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  reset, synchronous, active-low
  if_req_i  in  1  instruction-fetch request, held until granted
  if_addr_i  in  ADDR_WIDTH  fetch address
  if_gnt_o  out  1  fetch request accepted this cycle
  if_rvalid_o  out  1  fetch data valid, one-cycle pulse
  if_rdata_o  out  DATA_WIDTH  fetched instruction word
  d_req_i  in  1  load/store request, held until granted
  d_we_i  in  1  1=store, 0=load
  d_byte_i  in  1  byte access, forwarded to memory
  d_addr_i  in  ADDR_WIDTH  load/store address
  d_wdata_i  in  DATA_WIDTH  store data
  d_gnt_o  out  1  data request accepted this cycle
  d_rvalid_o  out  1  load data valid or store complete, one-cycle pulse
  d_rdata_o  out  DATA_WIDTH  load data
  mem_req_o  out  1  shared memory port active
  mem_we_o  out  1  memory write enable
  mem_byte_o  out  1  memory byte access
  mem_addr_o  out  ADDR_WIDTH  memory address
  mem_wdata_o  out  DATA_WIDTH  memory write data
  mem_rdata_i  in  DATA_WIDTH  memory read data
  busy_o  out  1  transaction in flight (state != IDLE)

Function
REQ-003 FSM SHALL have states IDLE, ACCESS, RESP; one transaction outstanding at most.
REQ-004 IDLE: if any request, winner's gnt_o SHALL assert combinationally same cycle; at edge latch owner, addr, we, byte, wdata; load counter = MEM_LATENCY-1; go ACCESS. No request: stay IDLE, both gnt_o 0.
REQ-005 gnt_o SHALL be 0 outside IDLE and whenever rst_n is 0; at most one gnt_o high per cycle.
REQ-006 ACCESS: mem_req_o=1, mem_we_o/mem_byte_o/mem_addr_o/mem_wdata_o from latched values; counter decrements each cycle; at counter==0 capture mem_rdata_i (0 for stores) and go RESP. Duration exactly MEM_LATENCY cycles.
REQ-007 mem_we_o SHALL be 1 only in ACCESS of a granted store; all mem_* outputs 0 in IDLE and RESP.
REQ-008 RESP: owner's rvalid_o=1 for exactly one cycle with rdata_o = captured word; other port's rvalid_o 0; go IDLE unconditionally.
REQ-009 rdata_o SHALL hold the last captured word until next capture; transaction latency grant-to-rvalid = MEM_LATENCY+1 cycles; throughput one transaction per MEM_LATENCY+2 cycles.
REQ-010 Requester inputs changing after grant SHALL be ignored; requests dropped before grant SHALL have no effect.
REQ-011 Default arbitration: both requesting in IDLE -> data port wins (older instruction).

Reset
REQ-012 On an edge with rst_n=0: state=IDLE, counter=0, latched regs and rdata=0, last-owner=DATA; all outputs 0 the following cycle.
REQ-013 Reset mid-ACCESS or mid-RESP SHALL abort the transaction: no rvalid_o pulse, mem_req_o 0 from next cycle.

Configuration
REQ-014 Macro ARB_RR_EN defined: tie SHALL go to port not granted last (last-owner updated on every grant; reset value DATA so first tie goes to fetch). Undefined: fixed data priority per REQ-011, last-owner unimplemented.

Verification (MEM_LATENCY=2)
REQ-015 Fetch read 0x00000010, mem_rdata_i=0x00500093 -> if_gnt_o cycle 0, mem_req_o cycles 1-2, if_rvalid_o cycle 3 with 0x00500093, busy_o cycles 1-3.
REQ-016 Without ARB_RR_EN, if_req_i (0x100) and d_req_i (0x2000 load) both at cycle 0 -> d_gnt_o cycle 0, d_rvalid_o cycle 3, if_gnt_o cycle 4, if_rvalid_o cycle 7.
REQ-017 Store d_addr_i=0x2004, d_wdata_i=0xAB, d_byte_i=1 -> mem_we_o=mem_byte_o=1 cycles 1-2 with addr 0x2004, d_rvalid_o cycle 3, d_rdata_o=0.
REQ-018 rst_n=0 during cycle 2 of a fetch -> cycle 3 shows mem_req_o=0, if_rvalid_o=0, busy_o=0.
REQ-019 With ARB_RR_EN, both requests held continuously after reset -> grant order fetch, data, fetch at cycles 0, 4, 8.
